ita_output_stage: RTL and testbench
===================================

// Module: ita_output_stage
// PURPOSE
//  Downstream of the ITA tile controller: buffers requantized N-wide output beats, tags each with a
//  destination address and byte strobe from the current tile coordinates, and streams them to memory.
//  Its oup_valid_o/oup_ready_i pair drives the controller's outstanding-output accounting.
//  Padding rows and columns beyond the real matrix dimensions are emitted with zero strobes.
// PARAMETERS
//  N            16  output vector width (elements per beat, WI bits each)
//  M            64  tile edge; one tile = M*M/N beats
//  OupFifoDepth 4   buffered entries (matches controller FifoDepth)
//  AddrW        32  byte-address width
// PORTS
//  clk_i             in   1          clock
//  rst_i             in   1          reset, synchronous, active-high
//  clear_i           in   1          sync flush of FIFO and beat counter
//  tile_x_i          in   counter_t  column-tile index of current tile
//  tile_y_i          in   counter_t  row-tile index of current tile
//  first_dim_i       in   counter_t  valid rows of output matrix
//  second_dim_i      in   counter_t  valid columns of output matrix
//  row_stride_i      in   AddrW      bytes between consecutive output rows
//  base_addr_i       in   AddrW      output matrix base address
//  inp_valid_i       in   1          requantized beat valid
//  inp_ready_o       out  1          beat accepted when valid & ready
//  inp_data_i        in   N*WI       requantized beat
//  oup_valid_o       out  1          output entry valid
//  oup_ready_i       in   1          output sink ready
//  oup_data_o        out  N*WI       output beat
//  oup_addr_o        out  AddrW      byte address of element 0 of beat
//  oup_strb_o        out  N          per-element write enable
//  oup_last_o        out  1          last beat of tile
//  err_o             out  1          sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_i=1 at posedge): FIFO empty, beat_q=0, oup_valid_o=0, err_o=0; inp_ready_o=0 while rst_i=1.
//  - inp_ready_o = !rst_i && (occupancy < OupFifoDepth); no pass-through when full, even if popping.
//  - Beat counter beat_q 0..M*M/N-1 increments per accepted beat, wraps to 0 after M*M/N-1.
//  - At beat 0 accept: latch tile_x/tile_y/first_dim/second_dim/row_stride/base into tile regs; beats
//    1..end use latched values. Beat 0 itself uses live inputs.
//  - Beat b: row r = b mod M, col group c = b / M. grow = tile_y*M + r; gcol = tile_x*M + c*N.
//  - addr = base + grow*row_stride + gcol (AddrW, wrap modulo 2^AddrW).
//  - strb: grow >= first_dim -> 0; else gcol >= second_dim -> 0; else gcol+N > second_dim ->
//    lower (second_dim-gcol) bits set; else all ones. Zero-strobe beats still emitted (order kept).
//  - oup_last_o = 1 on entry stored from beat M*M/N-1.
//  - Latency: accepted beat visible on oup_* earliest next cycle; pop when oup_valid_o & oup_ready_i.
//  - oup_* held stable while oup_valid_o & !oup_ready_i. Push and pop same cycle: occupancy unchanged.
//  - clear_i: priority over push/pop; next cycle FIFO empty, beat_q=0; err_o cleared.
// CONFIGURATION
//  ITA_OUP_CHECK_EN defined: err_o set (sticky) if an accepted beat with beat_q!=0 sees tile_x_i or
//    tile_y_i differing from latched values, or inp_valid_i drops mid-tile then clear_i not seen
//    before next beat 0 (only the first check is required). Not defined: err_o tied 0, no check logic.
// STRUCTURE
//  ita_package: oup_entry_t {data, addr, strb, last}, OupFifoDepth, oup_addr_t.
//  Sub-module ita_oup_fifo: synchronous FIFO of oup_entry_t (push/pop/full/empty/clear, active-high
//  sync reset). Address/strobe generation stays in top.
// TESTING  (M=64, N=16, base=0, 256 beats/tile)
//  1 tile (0,0), dims 64x64, stride 64 -> beat0 addr0, beat1 addr64, beat64 addr16, beat255 addr4080 last=1.
//  2 second_dim=40, tile_x=0 -> beats 128..191 strb 0x00FF; beats 192..255 strb 0x0000.
//  3 first_dim=70, tile_y=1 -> r=5 strb 0xFFFF; r>=6 strb 0x0000; addr r=6 = 70*stride.
//  4 oup_ready_i=0, push 4 beats -> inp_ready_o=0, oup_* stable; release -> 4 pops in order, 1/cycle.
//  5 clear_i at beat 100 with 3 queued -> next cycle oup_valid_o=0; next push addr0 (beat 0).
//  6 tile_x_i changed at beat 10 -> err_o=1 with ITA_OUP_CHECK_EN, stays 0 without; clear_i resets it.

Source files
------------

// File: rtl/ita_package.sv
// Shared types and sizing for the ITA output stage: tile geometry, address type and FIFO entry layout.
package ita_package;

    localparam int unsigned N            = 16;
    localparam int unsigned M            = 64;
    localparam int unsigned WI           = 8;
    localparam int unsigned OupFifoDepth = 4;
    localparam int unsigned AddrW        = 32;
    localparam int unsigned CntW         = 16;

    localparam int unsigned BeatsPerTile = M * M / N;
    localparam int unsigned BeatW        = $clog2(BeatsPerTile);
    localparam int unsigned RowW         = $clog2(M);

    typedef logic [CntW-1:0]  counter_t;
    typedef logic [AddrW-1:0] oup_addr_t;

    typedef struct packed {
        logic [N*WI-1:0] data;
        oup_addr_t       addr;
        logic [N-1:0]    strb;
        logic            last;
    } oup_entry_t;

endpackage

// File: rtl/ita_oup_fifo.sv
// Synchronous FIFO of output entries; clear_i flushes and has priority over push/pop.
module ita_oup_fifo
    import ita_package::*;
#(
    parameter int unsigned Depth = OupFifoDepth
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       push_i,
    input  oup_entry_t entry_i,
    input  logic       pop_i,
    output oup_entry_t entry_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    oup_entry_t      mem_q [Depth];
    logic [PtrW-1:0] wr_q, rd_q;
    logic [PtrW:0]   cnt_q;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == (PtrW+1)'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign entry_o = mem_q[rd_q];

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_q] <= entry_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= ptr_next(wr_q);
            if (do_pop)  rd_q <= ptr_next(rd_q);
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/ita_output_stage.sv
// Tags requantized beats with address/strobe from tile coordinates and buffers them towards memory.
// Optional ITA_OUP_CHECK_EN enables the sticky tile-coordinate consistency check on err_o.
module ita_output_stage
    import ita_package::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  counter_t          tile_x_i,
    input  counter_t          tile_y_i,
    input  counter_t          first_dim_i,
    input  counter_t          second_dim_i,
    input  logic [AddrW-1:0]  row_stride_i,
    input  logic [AddrW-1:0]  base_addr_i,
    input  logic              inp_valid_i,
    output logic              inp_ready_o,
    input  logic [N*WI-1:0]   inp_data_i,
    output logic              oup_valid_o,
    input  logic              oup_ready_i,
    output logic [N*WI-1:0]   oup_data_o,
    output logic [AddrW-1:0]  oup_addr_o,
    output logic [N-1:0]      oup_strb_o,
    output logic              oup_last_o,
    output logic              err_o
);

    logic [BeatW-1:0] beat_q, beat_d;
    counter_t         tx_q, ty_q, fd_q, sd_q;
    oup_addr_t        stride_q, base_q;

    counter_t         tx_s, ty_s, fd_s, sd_s;
    oup_addr_t        stride_s, base_s;
    oup_addr_t        grow, gcol;
    logic [RowW-1:0]  row;
    logic [BeatW-RowW-1:0] cgrp;

    logic       accept, pop, full, empty, tile_start;
    oup_entry_t entry_in, entry_out;

    assign inp_ready_o = !rst_i && !full;
    assign accept      = inp_valid_i && inp_ready_o;
    assign oup_valid_o = !empty;
    assign pop         = oup_valid_o && oup_ready_i;
    assign tile_start  = (beat_q == '0);

    // Beat 0 is tagged from the live inputs; the rest of the tile uses the copy latched with it.
    assign tx_s     = tile_start ? tile_x_i     : tx_q;
    assign ty_s     = tile_start ? tile_y_i     : ty_q;
    assign fd_s     = tile_start ? first_dim_i  : fd_q;
    assign sd_s     = tile_start ? second_dim_i : sd_q;
    assign stride_s = tile_start ? row_stride_i : stride_q;
    assign base_s   = tile_start ? base_addr_i  : base_q;

    assign row  = beat_q[RowW-1:0];
    assign cgrp = beat_q[BeatW-1:RowW];
    assign grow = AddrW'(ty_s) * AddrW'(M) + AddrW'(row);
    assign gcol = AddrW'(tx_s) * AddrW'(M) + AddrW'(cgrp) * AddrW'(N);

    always_comb begin
        entry_in      = '0;
        entry_in.data = inp_data_i;
        entry_in.addr = base_s + grow * stride_s + gcol;
        entry_in.last = (beat_q == BeatW'(BeatsPerTile - 1));
        for (int unsigned i = 0; i < N; i++) begin
            entry_in.strb[i] = (grow < AddrW'(fd_s)) && (gcol + AddrW'(i) < AddrW'(sd_s));
        end
    end

    always_comb begin
        beat_d = beat_q;
        if (clear_i) begin
            beat_d = '0;
        end else if (accept) begin
            beat_d = (beat_q == BeatW'(BeatsPerTile - 1)) ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q   <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            fd_q     <= '0;
            sd_q     <= '0;
            stride_q <= '0;
            base_q   <= '0;
        end else begin
            beat_q <= beat_d;
            if (accept && tile_start) begin
                tx_q     <= tile_x_i;
                ty_q     <= tile_y_i;
                fd_q     <= first_dim_i;
                sd_q     <= second_dim_i;
                stride_q <= row_stride_i;
                base_q   <= base_addr_i;
            end
        end
    end

    ita_oup_fifo #(
        .Depth (OupFifoDepth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (accept),
        .entry_i (entry_in),
        .pop_i   (pop),
        .entry_o (entry_out),
        .full_o  (full),
        .empty_o (empty)
    );

    assign oup_data_o = entry_out.data;
    assign oup_addr_o = entry_out.addr;
    assign oup_strb_o = entry_out.strb;
    assign oup_last_o = entry_out.last;

`ifdef ITA_OUP_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            err_q <= 1'b0;
        end else if (accept && !tile_start && (tile_x_i != tx_q || tile_y_i != ty_q)) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ita_output_stage.sv
// Randomized and directed bench for ita_output_stage against a queue-based reference model.
module tb_ita_output_stage;

`ifdef ITA_OUP_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_i, clear_i;
    logic [15:0]  tile_x_i, tile_y_i, first_dim_i, second_dim_i;
    logic [31:0]  row_stride_i, base_addr_i;
    logic         inp_valid_i, inp_ready_o;
    logic [127:0] inp_data_i;
    logic         oup_valid_o, oup_ready_i;
    logic [127:0] oup_data_o;
    logic [31:0]  oup_addr_o;
    logic [15:0]  oup_strb_o;
    logic         oup_last_o, err_o;

    always #5 clk_i = ~clk_i;

    ita_output_stage dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .tile_x_i     (tile_x_i),
        .tile_y_i     (tile_y_i),
        .first_dim_i  (first_dim_i),
        .second_dim_i (second_dim_i),
        .row_stride_i (row_stride_i),
        .base_addr_i  (base_addr_i),
        .inp_valid_i  (inp_valid_i),
        .inp_ready_o  (inp_ready_o),
        .inp_data_i   (inp_data_i),
        .oup_valid_o  (oup_valid_o),
        .oup_ready_i  (oup_ready_i),
        .oup_data_o   (oup_data_o),
        .oup_addr_o   (oup_addr_o),
        .oup_strb_o   (oup_strb_o),
        .oup_last_o   (oup_last_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic [127:0] data;
        logic [31:0]  addr;
        logic [15:0]  strb;
        logic         last;
        int           beat;
    } exp_t;

    exp_t        q[$];
    int          m_beat;
    bit          m_err;
    longint      l_tx, l_ty, l_fd, l_sd, l_stride, l_base;
    logic [31:0] obs_addr [256];
    logic [15:0] obs_strb [256];
    logic        obs_last [256];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Address and strobe straight from the tile geometry rules, in wide integer arithmetic.
    function automatic exp_t model_entry(int beat, longint tx, longint ty, longint fd, longint sd,
                                         longint stride, longint base, logic [127:0] data);
        exp_t   e;
        longint r, c, grow, gcol;
        r = beat % 64;
        c = beat / 64;
        grow = ty * 64 + r;
        gcol = tx * 64 + c * 16;
        e.data = data;
        e.addr = 32'((base + grow * stride + gcol) & 64'hFFFF_FFFF);
        if (grow >= fd)          e.strb = 16'h0000;
        else if (gcol >= sd)     e.strb = 16'h0000;
        else if (gcol + 16 > sd) e.strb = 16'((32'd1 << (sd - gcol)) - 1);
        else                     e.strb = 16'hFFFF;
        e.last = (beat == 255);
        e.beat = beat;
        return e;
    endfunction

    task automatic cycle(input bit v, input bit rdy, input bit clr, output bit acc);
        int   occ;
        exp_t e;
        @(negedge clk_i);
        inp_valid_i = v;
        inp_data_i  = {$urandom, $urandom, $urandom, $urandom};
        oup_ready_i = rdy;
        clear_i     = clr;
        #1;
        occ = q.size();
        acc = v && (occ < 4);
        chk("inp_ready", inp_ready_o, occ < 4);
        chk("oup_valid", oup_valid_o, occ != 0);
        chk("err", err_o, m_err);
        if (occ != 0) begin
            chk("oup_data", oup_data_o, q[0].data);
            chk("oup_addr", oup_addr_o, q[0].addr);
            chk("oup_strb", oup_strb_o, q[0].strb);
            chk("oup_last", oup_last_o, q[0].last);
        end
        if (clr) begin
            q.delete();
            m_beat = 0;
            m_err  = 1'b0;
            acc    = 1'b0;
        end else begin
            if (occ != 0 && rdy) begin
                obs_addr[q[0].beat] = oup_addr_o;
                obs_strb[q[0].beat] = oup_strb_o;
                obs_last[q[0].beat] = oup_last_o;
                void'(q.pop_front());
            end
            if (acc) begin
                if (m_beat == 0) begin
                    l_tx = tile_x_i;  l_ty = tile_y_i;
                    l_fd = first_dim_i; l_sd = second_dim_i;
                    l_stride = row_stride_i; l_base = base_addr_i;
                end else if (CHK && (tile_x_i != 16'(l_tx) || tile_y_i != 16'(l_ty))) begin
                    m_err = 1'b1;
                end
                e = model_entry(m_beat, l_tx, l_ty, l_fd, l_sd, l_stride, l_base, inp_data_i);
                q.push_back(e);
                m_beat = (m_beat + 1) % 256;
            end
        end
    endtask

    task automatic push_n(input int n, input bit rdy);
        bit acc;
        for (int i = 0; i < n; i++) begin
            int tries = 0;
            do begin
                cycle(1'b1, rdy, 1'b0, acc);
                tries++;
            end while (!acc && tries < 50);
            chk("push_timeout", acc, 1'b1);
        end
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 40 && q.size() != 0; k++) cycle(1'b0, 1'b1, 1'b0, acc);
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic set_tile(input int tx, input int ty, input int fd, input int sd,
                            input int stride, input int base);
        tile_x_i = 16'(tx); tile_y_i = 16'(ty);
        first_dim_i = 16'(fd); second_dim_i = 16'(sd);
        row_stride_i = 32'(stride); base_addr_i = 32'(base);
    endtask

    initial begin
        bit          acc;
        logic [31:0] a0;
        rst_i = 1'b1; clear_i = 1'b0; inp_valid_i = 1'b0; oup_ready_i = 1'b0; inp_data_i = '0;
        set_tile(0, 0, 64, 64, 64, 0);
        m_beat = 0; m_err = 1'b0;
        l_tx = 0; l_ty = 0; l_fd = 0; l_sd = 0; l_stride = 0; l_base = 0;
        repeat (2) @(negedge clk_i);
        inp_valid_i = 1'b1;
        #1;
        chk("rst_ready", inp_ready_o, 1'b0);
        chk("rst_valid", oup_valid_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        inp_valid_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;

        // 1: full 64x64 tile
        push_n(256, 1'b1);
        drain();
        chk("t1_addr0", obs_addr[0], 32'd0);
        chk("t1_addr1", obs_addr[1], 32'd64);
        chk("t1_addr64", obs_addr[64], 32'd16);
        chk("t1_addr255", obs_addr[255], 32'd4080);
        chk("t1_last255", obs_last[255], 1'b1);
        chk("t1_last254", obs_last[254], 1'b0);

        // 2: column padding
        set_tile(0, 0, 64, 40, 64, 0);
        push_n(256, 1'b1);
        drain();
        chk("t2_strb0", obs_strb[0], 16'hFFFF);
        chk("t2_strb128", obs_strb[128], 16'h00FF);
        chk("t2_strb191", obs_strb[191], 16'h00FF);
        chk("t2_strb192", obs_strb[192], 16'h0000);
        chk("t2_strb255", obs_strb[255], 16'h0000);

        // 3: row padding on second row-tile
        set_tile(0, 1, 70, 64, 128, 0);
        push_n(256, 1'b1);
        drain();
        chk("t3_strb5", obs_strb[5], 16'hFFFF);
        chk("t3_strb6", obs_strb[6], 16'h0000);
        chk("t3_strb63", obs_strb[63], 16'h0000);
        chk("t3_addr6", obs_addr[6], 32'd8960);

        // 4: back-pressure
        set_tile(0, 0, 64, 64, 64, 0);
        push_n(4, 1'b0);
        a0 = oup_addr_o;
        cycle(1'b1, 1'b0, 1'b0, acc);
        chk("t4_ready_full", inp_ready_o, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, acc);
        chk("t4_stable", oup_addr_o, a0);
        repeat (4) cycle(1'b0, 1'b1, 1'b0, acc);
        cycle(1'b0, 1'b1, 1'b0, acc);
        chk("t4_empty", oup_valid_o, 1'b0);
        for (int i = 0; i < 4; i++) chk("t4_order", obs_addr[i], 32'(i * 64));
        cycle(1'b0, 1'b1, 1'b1, acc);

        // 5: clear mid-tile with entries queued
        push_n(97, 1'b1);
        drain();
        push_n(3, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, acc);
        cycle(1'b0, 1'b1, 1'b0, acc);
        chk("t5_flushed", oup_valid_o, 1'b0);
        obs_addr[0] = '1;
        push_n(1, 1'b1);
        drain();
        chk("t5_addr_restart", obs_addr[0], 32'd0);
        cycle(1'b0, 1'b1, 1'b1, acc);

        // 6: tile coordinate change mid-tile
        push_n(10, 1'b1);
        tile_x_i = 16'd1;
        push_n(1, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, acc);
        chk("t6_err", err_o, CHK);
        tile_x_i = 16'd0;
        cycle(1'b0, 1'b1, 1'b1, acc);
        cycle(1'b0, 1'b1, 1'b0, acc);
        chk("t6_err_clr", err_o, 1'b0);

        // randomized traffic with changing geometry
        for (int n = 0; n < 4000; n++) begin
            if (m_beat == 0 || $urandom_range(0, 499) == 0) begin
                set_tile($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 300),
                         $urandom_range(0, 300), $urandom, $urandom);
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 199) == 0, acc);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
